proj_fm_minscan: RTL and testbench

PROJ_FM_MINSCAN -- requirements
Module: proj_fm_minscan

---
 rtl/proj_fm_minscan.sv | 132 +++++++++++++
 tb/tb_proj_fm_minscan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/proj_fm_minscan.sv
// proj_fm_minscan -- scans a window of fragment indices, hashes each returned
// fragment and reports the smallest hash together with the index that
// produced it.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        one-cycle pulse, begins a scan (ignored unless idle)
//   frag_idx     signed index to the fragment memory (0 when not scanning)
//   frag_rdata   fragment data, valid one cycle after frag_idx
//   busy         high whenever the block is not idle
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts the result
//   out_min_hash minimum hash of the scan
//   out_min_idx  index that produced out_min_hash
module proj_fm_minscan #(
  parameter int          FRAG_LEN          = 32,
  parameter int          SIGNED_INDICE_LEN = 12,
  parameter int          IDX_FIRST         = 0,
  parameter int          IDX_LAST          = 992,
  parameter int          STRIDE            = 2,
  parameter int          HASH_BITS         = 32,
  parameter logic [31:0] SEED              = 32'h5A5A_5A5A
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic signed [SIGNED_INDICE_LEN-1:0] frag_idx,
  input  logic [FRAG_LEN-1:0]                 frag_rdata,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [HASH_BITS-1:0]                out_min_hash,
  output logic signed [SIGNED_INDICE_LEN-1:0] out_min_idx
);
  localparam int W      = SIGNED_INDICE_LEN;
  localparam int N      = (IDX_LAST - IDX_FIRST) / STRIDE + 1;
  localparam int CW     = (N > 1) ? $clog2(N) : 1;
  localparam int STAGES = 2;
  localparam logic signed [W-1:0] FIRST_I  = W'(IDX_FIRST);
  localparam logic signed [W-1:0] STRIDE_I = W'(STRIDE);
  localparam logic [CW-1:0]       LAST_CNT = CW'(N - 1);
  localparam logic [31:0]         GOLDEN   = 32'h9E37_79B1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUT} state_t;

  state_t          state;
  logic [CW-1:0]   scan_cnt;
  logic [1:0]      drain_cnt;
  // [0]: frag_idx issued this cycle, [1]: frag_rdata valid, [2]: p valid
  logic [STAGES:0] vld_pipe;

  // Control. DRAIN holds for four cycles so the last hash has settled and
  // out_valid rises N+4 edges after the edge that sampled start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frag_idx  <= '0;
      scan_cnt  <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
      case (state)
        IDLE: if (start) begin
          state       <= SCAN;
          busy        <= 1'b1;
          frag_idx    <= FIRST_I;
          scan_cnt    <= '0;
          vld_pipe[0] <= 1'b1;
        end
        SCAN: if (scan_cnt == LAST_CNT) begin
          state     <= DRAIN;
          frag_idx  <= '0;
          drain_cnt <= '0;
        end else begin
          frag_idx    <= frag_idx + STRIDE_I;
          scan_cnt    <= scan_cnt + 1'b1;
          vld_pipe[0] <= 1'b1;
        end
        DRAIN: if (drain_cnt == 2'd3) begin
          state     <= OUT;
          out_valid <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt + 1'b1;
        end
        OUT: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Hash pipeline: stage 1 mixes and multiplies, stage 2 folds and compares.
  logic [31:0]         prod, p, h;
  logic signed [W-1:0] idx1, idx2;
  logic                first;

  assign prod = (frag_rdata[31:0] ^ SEED) * GOLDEN;
  assign h    = p ^ (p >> 15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p            <= '0;
      idx1         <= '0;
      idx2         <= '0;
      first        <= 1'b0;
      out_min_hash <= '0;
      out_min_idx  <= '0;
    end else begin
      idx1 <= frag_idx;
      if (vld_pipe[1]) begin
        p    <= prod;
        idx2 <= idx1;
      end
      if (state == IDLE && start) first <= 1'b1;
      // strict compare: an equal hash keeps the earlier (lower) index
      if (vld_pipe[2]) begin
        if (first || (h[HASH_BITS-1:0] < out_min_hash)) begin
          out_min_hash <= h[HASH_BITS-1:0];
          out_min_idx  <= idx2;
        end
        first <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_proj_fm_minscan.sv
module tb_proj_fm_minscan;
  localparam logic [31:0] SEED = 32'h5A5A_5A5A;
  localparam logic [31:0] GOLD = 32'h9E37_79B1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, ready_a, busy_a, valid_a;
  logic signed [11:0] frag_idx_a, min_idx_a;
  logic [31:0] rdata_a, min_hash_a;
  logic start_b, ready_b, busy_b, valid_b;
  logic signed [11:0] frag_idx_b, min_idx_b;
  logic [31:0] rdata_b, min_hash_b;

  proj_fm_minscan #(.IDX_FIRST(0), .IDX_LAST(6), .STRIDE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .frag_idx(frag_idx_a),
    .frag_rdata(rdata_a), .busy(busy_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_min_hash(min_hash_a), .out_min_idx(min_idx_a));

  proj_fm_minscan #(.IDX_FIRST(-2), .IDX_LAST(-2), .STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .frag_idx(frag_idx_b),
    .frag_rdata(rdata_b), .busy(busy_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_min_hash(min_hash_b), .out_min_idx(min_idx_b));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mhash(input logic [31:0] x);
    logic [31:0] p;
    p = (x ^ SEED) * GOLD;
    return p ^ (p >> 15);
  endfunction

  // data word whose model hash is exactly h
  function automatic logic [31:0] preimage(input logic [31:0] h);
    logic [31:0] p, inv;
    p = h ^ (h >> 15) ^ (h >> 30);
    inv = GOLD;
    repeat (5) inv = inv * (32'd2 - GOLD * inv);
    return (p * inv) ^ SEED;
  endfunction

  // fragment memories: one-cycle registered read
  logic [31:0] data_a [4];
  always @(posedge clk)
    rdata_a <= (frag_idx_a >= 0 && frag_idx_a <= 6 && !frag_idx_a[0]) ?
               data_a[frag_idx_a[2:1]] : 32'hDEAD_BEEF;
  always @(posedge clk)
    rdata_b <= (frag_idx_b == -12'sd2) ? 32'h0BAD_F00D : 32'h0;

  typedef struct { logic [31:0] h; logic signed [11:0] idx; } res_t;
  res_t sb_a[$];

  // scoreboard: compare each accepted result against the expectation queued at start
  always @(negedge clk) begin
    #1;
    if (!rst && valid_a && ready_a) begin
      if (sb_a.size() == 0) chk("sb_unexpected_result", 32'd1, 32'd0);
      else begin
        res_t e;
        e = sb_a.pop_front();
        chk("sb_min_hash", min_hash_a, e.h);
        chk("sb_min_idx", 32'(min_idx_a), 32'(e.idx));
      end
    end
  end

  typedef struct { string nm; logic [31:0] d [4]; int exp_slot; } vec_t;
  vec_t vecs [4];

  // called at a negedge; returns at the negedge after the handshake edge
  task automatic scan_a(input int v, input int hold, input bit poke_start);
    int c;
    logic [31:0] hh;
    logic signed [11:0] hi;
    res_t e;
    for (int i = 0; i < 4; i++) data_a[i] = vecs[v].d[i];
    e.h = mhash(vecs[v].d[vecs[v].exp_slot]);
    e.idx = 12'(2 * vecs[v].exp_slot);
    sb_a.push_back(e);
    ready_a = (hold == 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    c = 0;
    while (!valid_a && c < 30) begin
      if (c <= 4) chk($sformatf("%s_frag_idx_c%0d", vecs[v].nm, c),
                      32'(frag_idx_a), (c < 4) ? 32'(2 * c) : 32'd0);
      @(negedge clk);
      c++;
    end
    chk({vecs[v].nm, "_latency"}, 32'(c), 32'd8);
    if (hold > 0) begin
      hh = min_hash_a;
      hi = min_idx_a;
      for (int i = 0; i < hold; i++) begin
        start_a = poke_start && (i == 1);
        @(negedge clk);
        chk("hold_valid", 32'(valid_a), 32'd1);
        chk("hold_hash", min_hash_a, hh);
        chk("hold_idx", 32'(min_idx_a), 32'(hi));
      end
      start_a = 1'b0;
      ready_a = 1'b1;
    end
    @(negedge clk);
    chk({vecs[v].nm, "_busy_after_hs"}, 32'(busy_a), 32'd0);
    chk({vecs[v].nm, "_valid_after_hs"}, 32'(valid_a), 32'd0);
    if (poke_start) begin
      @(negedge clk);
      chk("start_not_queued", 32'(busy_a), 32'd0);
    end
  endtask

  initial begin
    int c;
    bit seen;
    vecs[0] = '{nm: "zeros", d: '{32'h0, 32'h0, 32'h0, 32'h0}, exp_slot: 0};
    vecs[1] = '{nm: "min_at4", d: '{32'hA5A5_A5A5, 32'h3C3C_3C3C, preimage(32'd1), 32'h1234_5678}, exp_slot: 2};
    vecs[2] = '{nm: "tie", d: '{32'h1111_1111, preimage(32'd5), 32'h2222_2222, preimage(32'd5)}, exp_slot: 1};
    vecs[3] = '{nm: "min_at6", d: '{preimage(32'd7), 32'hCAFE_0001, 32'h7777_0000, preimage(32'd0)}, exp_slot: 3};

    rst = 1'b1; start_a = 0; start_b = 0; ready_a = 1; ready_b = 1;
    for (int i = 0; i < 4; i++) data_a[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_frag_idx", 32'(frag_idx_a), 32'd0);
    chk("rst_min_hash", min_hash_a, 32'd0);
    chk("rst_min_idx", 32'(min_idx_a), 32'd0);
    rst = 1'b0;

    // first edge after reset samples start; scans run back to back
    for (int v = 0; v < 4; v++) scan_a(v, 0, 1'b0);
    scan_a(1, 5, 1'b1);

    // reset in the third SCAN cycle aborts the scan
    for (int i = 0; i < 4; i++) data_a[i] = vecs[2].d[i];
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_frag_idx", 32'(frag_idx_a), 32'd0);
    chk("async_rst_busy", 32'(busy_a), 32'd0);
    chk("async_rst_valid", 32'(valid_a), 32'd0);
    chk("async_rst_min_hash", min_hash_a, 32'd0);
    chk("async_rst_min_idx", 32'(min_idx_a), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    seen = 1'b0;
    repeat (15) begin
      if (valid_a || busy_a) seen = 1'b1;
      @(negedge clk);
    end
    chk("no_valid_after_abort", 32'(seen), 32'd0);
    scan_a(1, 0, 1'b0);

    // single-index window at -2
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("n1_frag_idx_c0", 32'(frag_idx_b), 32'(-12'sd2));
    c = 0;
    while (!valid_b && c < 30) begin
      @(negedge clk);
      c++;
      if (c == 1) chk("n1_frag_idx_c1", 32'(frag_idx_b), 32'd0);
    end
    chk("n1_latency", 32'(c), 32'd5);
    chk("n1_min_idx", 32'(min_idx_b), 32'(-12'sd2));
    chk("n1_min_hash", min_hash_b, mhash(32'h0BAD_F00D));
    @(negedge clk);
    chk("n1_busy_after_hs", 32'(busy_b), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_a.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
